// File: rtl/wb_ext_pkg.sv
// Shared types and constants for the Wishbone to ext_data bridge.
package wb_ext_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      ACK  = 2'd3
   } wb_ext_state_e;

   localparam logic [31:0] WB_EXT_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_ext_timeout.sv
// Saturating cycle counter used by the bridge to abort stalled ext transactions.
module wb_ext_timeout #(
   parameter int unsigned MAX = 255
) (
   input  logic clk_i,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned W = (MAX == 0) ? 1 : $clog2(MAX + 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset || clear_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/wb_ext_bridge.sv
// Classic Wishbone slave to ext_data req/gnt/rvalid master, one transaction in flight.
// Optional stall abort with timeout_o pulse is compiled in by WB_EXT_TIMEOUT_EN.
module wb_ext_bridge
   import wb_ext_pkg::*;
#(
   parameter logic [31:0] ADDR_MASK      = 32'h0000_0FFF,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
`ifdef WB_EXT_TIMEOUT_EN
   output logic        timeout_o,
`endif
   output logic        ext_data_req_o,
   output logic [31:0] ext_data_addr_o,
   output logic [3:0]  ext_data_be_o,
   output logic        ext_data_we_o,
   output logic [31:0] ext_data_wdata_o,
   input  logic        ext_data_gnt_i,
   input  logic        ext_data_rvalid_i,
   input  logic [31:0] ext_data_rdata_i
);

   wb_ext_state_e state_q;
   logic          req_q;
   logic          we_q;
   logic [3:0]    be_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   data_q;
   // Cleared when the master abandons the cycle after the ext side accepted it.
   logic          ack_ok_q;

`ifdef WB_EXT_TIMEOUT_EN
   logic timeout_q;
   logic expired;

   wb_ext_timeout #(
      .MAX (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .reset     (reset),
      .clear_i   (state_q == IDLE),
      .en_i      ((state_q == REQ) || (state_q == RESP)),
      .expired_o (expired)
   );

   assign timeout_o = timeout_q;
`endif

   // NOTE: non-blocking assignments only, so every branch sees pre-edge register values.
   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         data_q   <= '0;
         ack_ok_q <= 1'b0;
`ifdef WB_EXT_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
      end else begin
`ifdef WB_EXT_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (wbs_stb_i && wbs_cyc_i) begin
                  addr_q   <= wbs_adr_i & ADDR_MASK;
                  wdata_q  <= wbs_dat_i;
                  be_q     <= wbs_sel_i;
                  we_q     <= wbs_we_i;
                  data_q   <= '0;
                  ack_ok_q <= 1'b1;
                  req_q    <= 1'b1;
                  state_q  <= REQ;
               end
            end
            REQ: begin
               if (ext_data_gnt_i) begin
                  req_q    <= 1'b0;
                  ack_ok_q <= wbs_cyc_i;
                  state_q  <= we_q ? ACK : RESP;
               end else if (!wbs_cyc_i) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
`ifdef WB_EXT_TIMEOUT_EN
               end else if (expired) begin
                  req_q     <= 1'b0;
                  data_q    <= WB_EXT_ABORT_DATA;
                  timeout_q <= 1'b1;
                  state_q   <= ACK;
`endif
               end
            end
            RESP: begin
               if (!wbs_cyc_i) begin
                  ack_ok_q <= 1'b0;
               end
               if (ext_data_rvalid_i) begin
                  data_q  <= ext_data_rdata_i;
                  state_q <= ACK;
`ifdef WB_EXT_TIMEOUT_EN
               end else if (expired) begin
                  data_q    <= WB_EXT_ABORT_DATA;
                  timeout_q <= 1'b1;
                  state_q   <= ACK;
`endif
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o        = (state_q == ACK) && wbs_cyc_i && ack_ok_q;
   assign wbs_dat_o        = (state_q == ACK) ? data_q : 32'h0;
   assign ext_data_req_o   = req_q;
   assign ext_data_addr_o  = addr_q;
   assign ext_data_be_o    = be_q;
   assign ext_data_we_o    = we_q;
   assign ext_data_wdata_o = wdata_q;

endmodule

// File: tb/tb_wb_ext_bridge.sv
// Scoreboard bench for wb_ext_bridge; define WB_EXT_TIMEOUT_EN to also exercise the abort path.
module tb_wb_ext_bridge;

   localparam logic [31:0] MASK = 32'h0000_0FFF;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      int          len;
   } ext_exp_t;

   typedef struct {
      logic [31:0] data;
      int          cycle;
   } ack_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_we_i = 1'b0;
   logic [3:0]  wbs_sel_i = '0;
   logic [31:0] wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        ext_data_req_o;
   logic [31:0] ext_data_addr_o;
   logic [3:0]  ext_data_be_o;
   logic        ext_data_we_o;
   logic [31:0] ext_data_wdata_o;
   logic        ext_data_gnt_i = 1'b0;
   logic        ext_data_rvalid_i = 1'b0;
   logic [31:0] ext_data_rdata_i = '0;
`ifdef WB_EXT_TIMEOUT_EN
   logic        timeout_o;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt = 0;
   int ack_cnt = 0;
   int to_cnt = 0;
   int req_len = 0;
   int req_rise_cycle = 0;
   int last_ack_cycle = 0;
   bit mon_en = 1'b0;

   ext_exp_t sb_ext[$];
   ack_exp_t sb_ack[$];

   wb_ext_bridge #(
      .ADDR_MASK      (MASK),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i             (clk),
      .reset             (reset),
      .wbs_stb_i         (wbs_stb_i),
      .wbs_cyc_i         (wbs_cyc_i),
      .wbs_we_i          (wbs_we_i),
      .wbs_sel_i         (wbs_sel_i),
      .wbs_adr_i         (wbs_adr_i),
      .wbs_dat_i         (wbs_dat_i),
      .wbs_ack_o         (wbs_ack_o),
      .wbs_dat_o         (wbs_dat_o),
`ifdef WB_EXT_TIMEOUT_EN
      .timeout_o         (timeout_o),
`endif
      .ext_data_req_o    (ext_data_req_o),
      .ext_data_addr_o   (ext_data_addr_o),
      .ext_data_be_o     (ext_data_be_o),
      .ext_data_we_o     (ext_data_we_o),
      .ext_data_wdata_o  (ext_data_wdata_o),
      .ext_data_gnt_i    (ext_data_gnt_i),
      .ext_data_rvalid_i (ext_data_rvalid_i),
      .ext_data_rdata_i  (ext_data_rdata_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_cnt);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: compares ext request fields and Wishbone acks against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ext_data_req_o) begin
            if (sb_ext.size() == 0) begin
               check("spurious_req", {31'd0, ext_data_req_o}, 32'd0);
            end else begin
               if (req_len == 0) req_rise_cycle = cyc_cnt;
               req_len++;
               check("ext_addr", ext_data_addr_o, sb_ext[0].addr);
               check("ext_be", {28'd0, ext_data_be_o}, {28'd0, sb_ext[0].be});
               check("ext_we", {31'd0, ext_data_we_o}, {31'd0, sb_ext[0].we});
               check("ext_wdata", ext_data_wdata_o, sb_ext[0].wdata);
            end
         end else if (req_len > 0) begin
            check("req_len", 32'(req_len), 32'(sb_ext[0].len));
            void'(sb_ext.pop_front());
            req_len = 0;
         end

         if (sb_ack.size() == 0) begin
            check("spurious_ack", {31'd0, wbs_ack_o}, 32'd0);
         end else if (wbs_ack_o) begin
            check("ack_data", wbs_dat_o, sb_ack[0].data);
            check("ack_cycle", 32'(cyc_cnt), 32'(sb_ack[0].cycle));
            void'(sb_ack.pop_front());
         end
         if (wbs_ack_o) begin
            ack_cnt++;
            last_ack_cycle = cyc_cnt;
         end else begin
            check("dat_idle", wbs_dat_o, 32'd0);
         end
`ifdef WB_EXT_TIMEOUT_EN
         if (timeout_o) begin
            to_cnt++;
            check("timeout_with_ack", {31'd0, wbs_ack_o}, 32'd1);
         end
`endif
      end
   end

   task automatic start_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int req_cycles);
      ext_exp_t e;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      e.addr  = adr & MASK;
      e.be    = sel;
      e.we    = we;
      e.wdata = dat;
      e.len   = req_cycles;
      sb_ext.push_back(e);
   endtask

   task automatic end_cycle();
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
   endtask

   // Full transaction; returns in the IDLE cycle following the ack.
   task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rdata, input bit keep);
      ack_exp_t a;
      int acks_before;
      acks_before = ack_cnt;
      start_cycle(we, adr, dat, sel, gnt_dly + 1);
      a.data  = we ? 32'd0 : rdata;
      a.cycle = cyc_cnt + (we ? 2 + gnt_dly : 2 + gnt_dly + rv_dly);
      sb_ack.push_back(a);
      tick();
      repeat (gnt_dly) tick();
      ext_data_gnt_i = 1'b1;
      tick();
      ext_data_gnt_i = 1'b0;
      if (!we) begin
         repeat (rv_dly - 1) tick();
         ext_data_rvalid_i = 1'b1;
         ext_data_rdata_i  = rdata;
         tick();
         ext_data_rvalid_i = 1'b0;
         ext_data_rdata_i  = 32'hFFFF_FFFF;
      end
      tick();
      if (!keep) end_cycle();
      check("one_ack", 32'(ack_cnt - acks_before), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_cnt);
      $fatal(1);
   end

   initial begin
      int first_ack;
      int acks_before;

      repeat (2) tick();
      check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_req", {31'd0, ext_data_req_o}, 32'd0);
      check("rst_addr", ext_data_addr_o, 32'd0);
      check("rst_be", {28'd0, ext_data_be_o}, 32'd0);
      check("rst_we", {31'd0, ext_data_we_o}, 32'd0);
      check("rst_wdata", ext_data_wdata_o, 32'd0);
`ifdef WB_EXT_TIMEOUT_EN
      check("rst_timeout", {31'd0, timeout_o}, 32'd0);
`endif
      reset  = 1'b0;
      mon_en = 1'b1;
      tick();

      // Minimum-latency write, then a read with a stalled grant and late rvalid.
      do_xfer(1'b1, 32'h3000_0124, 32'hA5A5_0001, 4'hF, 0, 0, 32'h0, 1'b0);
      tick();
      do_xfer(1'b0, 32'h3000_0040, 32'h5555_AAAA, 4'hF, 3, 2, 32'h1234_5678, 1'b0);
      tick();

      // Back-to-back with stb held: the next req follows the ack after one IDLE cycle.
      do_xfer(1'b1, 32'h3000_0200, 32'hCAFE_F00D, 4'h3, 0, 0, 32'h0, 1'b1);
      first_ack = last_ack_cycle;
      do_xfer(1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hC, 0, 1, 32'h0BAD_C0DE, 1'b0);
      check("b2b_gap", 32'(req_rise_cycle - first_ack), 32'd2);
      tick();

      // Master abandons the cycle while the request is still waiting for a grant.
      acks_before = ack_cnt;
      start_cycle(1'b0, 32'h3000_0500, 32'h0000_0011, 4'hF, 1);
      tick();
      end_cycle();
      tick();
      check("req_drop", {31'd0, ext_data_req_o}, 32'd0);
      repeat (3) tick();
      check("drop_no_ack", 32'(ack_cnt - acks_before), 32'd0);
      do_xfer(1'b0, 32'h3000_0504, 32'h0, 4'h1, 1, 1, 32'h7777_0001, 1'b0);
      tick();

      // Reset while waiting for read data; a stray rvalid afterwards is ignored.
      acks_before = ack_cnt;
      start_cycle(1'b0, 32'h3000_0300, 32'h0000_0022, 4'hF, 1);
      tick();
      ext_data_gnt_i = 1'b1;
      tick();
      ext_data_gnt_i = 1'b0;
      reset = 1'b1;
      tick();
      check("rr_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rr_dat", wbs_dat_o, 32'd0);
      check("rr_req", {31'd0, ext_data_req_o}, 32'd0);
      check("rr_addr", ext_data_addr_o, 32'd0);
      check("rr_be", {28'd0, ext_data_be_o}, 32'd0);
      check("rr_we", {31'd0, ext_data_we_o}, 32'd0);
      check("rr_wdata", ext_data_wdata_o, 32'd0);
      reset = 1'b0;
      end_cycle();
      tick();
      ext_data_rvalid_i = 1'b1;
      ext_data_rdata_i  = 32'h9999_9999;
      tick();
      ext_data_rvalid_i = 1'b0;
      repeat (3) tick();
      check("rr_no_ack", 32'(ack_cnt - acks_before), 32'd0);

`ifdef WB_EXT_TIMEOUT_EN
      // Read that never receives a grant: abort after TIMEOUT_CYCLES counted in REQ.
      begin
         ack_exp_t a;
         start_cycle(1'b0, 32'h3000_0600, 32'h0000_0033, 4'hF, 9);
         a.data  = 32'hDEAD_BEEF;
         a.cycle = cyc_cnt + 10;
         sb_ack.push_back(a);
         tick();
         for (int i = 0; i < 40 && !wbs_ack_o; i++) tick();
         check("to_ack_seen", {31'd0, wbs_ack_o}, 32'd1);
         tick();
         end_cycle();
         tick();
         check("to_pulses", 32'(to_cnt), 32'd1);
      end
`endif

      repeat (2) tick();
      check("sb_ext_empty", 32'(sb_ext.size()), 32'd0);
      check("sb_ack_empty", 32'(sb_ack.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
